// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer and the data memory it fronts:
// bus widths, default memory size, the address-valid compare and the port ops.
package store_buffer_pkg;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int RAM_SIZE_DEF = 256;

  // What the single memory port does in a given cycle, highest priority first.
  typedef enum logic [1:0] {
    PORT_FORCED = 2'd0,
    PORT_LOAD   = 2'd1,
    PORT_DRAIN  = 2'd2,
    PORT_IDLE   = 2'd3
  } port_op_e;

  // An address is usable only if it falls inside the word-addressed RAM.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr,
                                   input int unsigned       ram_size);
    return addr < ADDR_W'(ram_size);
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Store-to-load forwarding lookup: compares the load address with every
// occupied buffer entry and returns the youngest matching store's data.
module sb_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic [ADDR_W-1:0]             i_addr,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  i_ent_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  i_ent_data,
  input  logic [PTR_W-1:0]              i_head,
  input  logic [PTR_W:0]                i_count,
  output logic                          o_hit,
  output logic [DATA_W-1:0]             o_data
);

  logic [PTR_W-1:0] w_idx;

  // Walk from oldest (head) to youngest (tail-1); later matches override earlier.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = i_head + PTR_W'(i);
      if (((PTR_W+1)'(i) < i_count) && (i_ent_addr[w_idx] == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_ent_data[w_idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Write-posting store buffer between the CPU memory stage and a single-port
// data memory. Stores are queued and drained when the port is free; loads
// take the port first and are forwarded from the youngest pending store.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int RAM_SIZE = RAM_SIZE_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_accessable,
  output logic              stall,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]             r_head;
  logic [PTR_W-1:0]             r_tail;
  logic [PTR_W:0]               r_count;
  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;

  logic              w_valid;
  logic              w_req;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_hit;
  logic [DATA_W-1:0] w_hit_data;
  port_op_e          w_op;

  assign w_valid = addr_ok(cpu_addr, RAM_SIZE);
  assign w_req   = cpu_rd | cpu_wr;
  assign w_full  = (r_count == (PTR_W+1)'(DEPTH));

  sb_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match (
    .i_addr     (cpu_addr),
    .i_ent_addr (r_addr),
    .i_ent_data (r_data),
    .i_head     (r_head),
    .i_count    (r_count),
    .o_hit      (w_hit),
    .o_data     (w_hit_data)
  );

  // Pick this cycle's port owner: a full buffer must drain before any request,
  // then loads, then opportunistic draining when the CPU is not loading.
  always_comb begin
    w_op = PORT_IDLE;
    if (w_full && w_req)
      w_op = PORT_FORCED;
    else if (cpu_rd && w_valid)
      w_op = PORT_LOAD;
    else if (!cpu_rd && (r_count != '0))
      w_op = PORT_DRAIN;
  end

  // Drive the memory port from the chosen op; unused fields stay at zero.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (w_op)
      PORT_LOAD: begin
        mem_rd   = 1'b1;
        mem_addr = cpu_addr;
      end
      PORT_FORCED, PORT_DRAIN: begin
        mem_wr    = 1'b1;
        mem_addr  = r_addr[r_head];
        mem_wdata = r_data[r_head];
      end
      default: ;
    endcase
  end

  assign stall          = (w_op == PORT_FORCED);
  assign w_pop          = (w_op == PORT_FORCED) || (w_op == PORT_DRAIN);
  assign w_push         = cpu_wr && w_valid && !stall;
  assign cpu_accessable = !(w_req && !w_valid);
  // The same-cycle store is not yet in the entry array, so a combined
  // load+store sees only older data.
  assign cpu_rdata      = (cpu_rd && w_valid) ? (w_hit ? w_hit_data : mem_rdata) : '0;

  // FIFO bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload is plain storage; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= cpu_addr;
      r_data[r_tail] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioural single-port data memory.
module tb_store_buffer;

  logic        clk;
  logic        reset_n;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_accessable;
  logic        stall;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] tb_mem [0:255];
  logic        tb_mem_init;

  int tests;
  int fails;

  store_buffer #(
    .DEPTH    (4),
    .RAM_SIZE (256)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cpu_rd         (cpu_rd),
    .cpu_wr         (cpu_wr),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_accessable (cpu_accessable),
    .stall          (stall),
    .mem_rd         (mem_rd),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on posedge, presets while initialising.
  assign mem_rdata = (mem_addr < 32'd256) ? tb_mem[mem_addr[7:0]] : 32'h0;
  always @(posedge clk) begin
    if (tb_mem_init) begin
      for (int k = 0; k < 256; k++) tb_mem[k] <= 32'h0;
      tb_mem[8'h42] <= 32'h99;
      tb_mem[8'h51] <= 32'hAB;
    end else if (mem_wr) begin
      tb_mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle's request at the negedge and let combinational outputs settle.
  task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_addr  = a;
    cpu_wdata = d;
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n     = 1'b0;
    tb_mem_init = 1'b1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Reset state: load passes straight to memory, nothing else active
    step(1, 0, 32'd5, 0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_mem_rd", {31'b0, mem_rd}, 32'd1);
    step(0, 0, 0, 0);
    chk("rst_idle_mem_rd", {31'b0, mem_rd}, 32'd0);
    tb_mem_init = 1'b0;
    reset_n     = 1'b1;

    // Three back-to-back stores drain in order while later ones are posted
    step(0, 1, 32'd1, 32'hA1);
    chk("t1_c0_stall", {31'b0, stall}, 32'd0);
    chk("t1_c0_mem_wr", {31'b0, mem_wr}, 32'd0);
    step(0, 1, 32'd2, 32'hA2);
    chk("t1_c1_stall", {31'b0, stall}, 32'd0);
    chk("t1_c1_mem_wr", {31'b0, mem_wr}, 32'd1);
    chk("t1_c1_addr", mem_addr, 32'd1);
    chk("t1_c1_data", mem_wdata, 32'hA1);
    step(0, 1, 32'd3, 32'hA3);
    chk("t1_c2_addr", mem_addr, 32'd2);
    chk("t1_c2_data", mem_wdata, 32'hA2);
    step(0, 0, 0, 0);
    chk("t1_c3_mem_wr", {31'b0, mem_wr}, 32'd1);
    chk("t1_c3_addr", mem_addr, 32'd3);
    chk("t1_c3_data", mem_wdata, 32'hA3);
    step(0, 0, 0, 0);
    chk("t1_c4_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("t1_c4_mem_addr", mem_addr, 32'd0);
    step(0, 0, 0, 0);
    chk("t1_c5_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("t1_mem1", tb_mem[1], 32'hA1);
    chk("t1_mem2", tb_mem[2], 32'hA2);
    chk("t1_mem3", tb_mem[3], 32'hA3);

    // Youngest of two same-address stores is forwarded
    step(0, 1, 32'h10, 32'h11);
    step(0, 1, 32'h10, 32'h22);
    step(1, 0, 32'h10, 0);
    chk("t2_fwd", cpu_rdata, 32'h22);
    chk("t2_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("t2_mem_rd", {31'b0, mem_rd}, 32'd1);
    step(0, 0, 0, 0);
    chk("t2_drain_data", mem_wdata, 32'h22);
    step(0, 0, 0, 0);
    chk("t2_empty", {31'b0, mem_wr}, 32'd0);

    // Fill four entries with combined load+store, then a store forces a drain
    step(1, 1, 32'h30, 32'h1);
    chk("t3_ld_rdata", cpu_rdata, 32'h0);
    chk("t3_ld_mem_wr", {31'b0, mem_wr}, 32'd0);
    step(1, 1, 32'h31, 32'h2);
    step(1, 1, 32'h32, 32'h3);
    step(1, 1, 32'h33, 32'h4);
    chk("t3_ld4_stall", {31'b0, stall}, 32'd0);
    step(0, 1, 32'h20, 32'h55);
    chk("t3_forced_stall", {31'b0, stall}, 32'd1);
    chk("t3_forced_mem_wr", {31'b0, mem_wr}, 32'd1);
    chk("t3_forced_addr", mem_addr, 32'h30);
    chk("t3_forced_data", mem_wdata, 32'h1);
    step(0, 1, 32'h20, 32'h55);
    chk("t3_retry_stall", {31'b0, stall}, 32'd0);
    chk("t3_retry_addr", mem_addr, 32'h31);
    step(0, 0, 0, 0);
    chk("t3_d2_addr", mem_addr, 32'h32);
    step(0, 0, 0, 0);
    chk("t3_d3_addr", mem_addr, 32'h33);
    step(0, 0, 0, 0);
    chk("t3_d4_addr", mem_addr, 32'h20);
    chk("t3_d4_data", mem_wdata, 32'h55);
    step(0, 0, 0, 0);
    chk("t3_empty", {31'b0, mem_wr}, 32'd0);
    chk("t3_mem20", tb_mem[8'h20], 32'h55);
    chk("t3_mem30", tb_mem[8'h30], 32'h1);

    // Continuous loads hold off draining; forwarding and memory reads both correct
    step(1, 1, 32'h40, 32'h66);
    step(1, 1, 32'h41, 32'h77);
    step(1, 0, 32'h40, 0);
    chk("t4_l0_rdata", cpu_rdata, 32'h66);
    chk("t4_l0_mem_wr", {31'b0, mem_wr}, 32'd0);
    step(1, 0, 32'h41, 0);
    chk("t4_l1_rdata", cpu_rdata, 32'h77);
    step(1, 0, 32'h42, 0);
    chk("t4_l2_rdata", cpu_rdata, 32'h99);
    chk("t4_l2_mem_wr", {31'b0, mem_wr}, 32'd0);
    step(1, 0, 32'h40, 0);
    chk("t4_l3_rdata", cpu_rdata, 32'h66);
    step(1, 0, 32'h41, 0);
    chk("t4_l4_rdata", cpu_rdata, 32'h77);
    chk("t4_l4_mem_wr", {31'b0, mem_wr}, 32'd0);
    step(0, 0, 0, 0);
    chk("t4_d0_mem_wr", {31'b0, mem_wr}, 32'd1);
    chk("t4_d0_addr", mem_addr, 32'h40);
    chk("t4_d0_data", mem_wdata, 32'h66);
    step(0, 0, 0, 0);
    chk("t4_d1_addr", mem_addr, 32'h41);
    step(0, 0, 0, 0);
    chk("t4_empty", {31'b0, mem_wr}, 32'd0);

    // Out-of-range address is rejected without touching the buffer or memory
    step(0, 1, 32'd300, 32'hDEAD);
    chk("t5_wr_acc", {31'b0, cpu_accessable}, 32'd0);
    chk("t5_wr_stall", {31'b0, stall}, 32'd0);
    chk("t5_wr_mem_wr", {31'b0, mem_wr}, 32'd0);
    step(1, 0, 32'd300, 0);
    chk("t5_rd_acc", {31'b0, cpu_accessable}, 32'd0);
    chk("t5_rd_rdata", cpu_rdata, 32'h0);
    chk("t5_rd_mem_rd", {31'b0, mem_rd}, 32'd0);
    step(0, 0, 0, 0);
    chk("t5_no_push", {31'b0, mem_wr}, 32'd0);
    chk("t5_idle_acc", {31'b0, cpu_accessable}, 32'd1);

    // Asynchronous reset in the middle of a drain discards buffered stores
    step(1, 1, 32'h50, 32'h1);
    step(1, 1, 32'h51, 32'h2);
    chk("t6_ld_mem", cpu_rdata, 32'hAB);
    step(1, 1, 32'h52, 32'h3);
    step(0, 0, 0, 0);
    chk("t6_drain_mem_wr", {31'b0, mem_wr}, 32'd1);
    chk("t6_drain_addr", mem_addr, 32'h50);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("t6_rst_stall", {31'b0, stall}, 32'd0);
    step(0, 0, 0, 0);
    chk("t6_rst_hold_mem_wr", {31'b0, mem_wr}, 32'd0);
    reset_n = 1'b1;
    step(1, 0, 32'h51, 0);
    chk("t6_post_rdata", cpu_rdata, 32'hAB);
    chk("t6_post_mem_rd", {31'b0, mem_rd}, 32'd1);
    step(0, 0, 0, 0);
    chk("t6_post_empty", {31'b0, mem_wr}, 32'd0);
    chk("t6_mem50", tb_mem[8'h50], 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-posting store buffer between the CPU memory-access stage and the single-port data memory. Accepts CPU stores into a small FIFO so they complete without a memory cycle, drains them one per cycle whenever the memory port is not needed by a load, and forwards the youngest buffered data to loads that hit a pending store. Presents the data memory's combinational-read, clocked-write port to the CPU, plus a stall output.

## Interface
- DEPTH, 4: buffer entries; power of two, 2..16.
- RAM_SIZE, 256: word-addressed data memory size; addresses >= RAM_SIZE are invalid.
- clk  in  1  system clock, all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_rd  in  1  load request this cycle.
- cpu_wr  in  1  store request this cycle.
- cpu_addr  in  32  word address.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data, combinational; 0 when cpu_rd=0 or the address is invalid.
- cpu_accessable  out  1  0 when (cpu_rd|cpu_wr) and cpu_addr >= RAM_SIZE.
- stall  out  1  combinational; CPU must hold its request and retry next cycle.
- mem_rd, mem_wr  out  1 each  data memory strobes.
- mem_addr, mem_wdata  out  32 each  data memory address/data.
- mem_rdata  in  32  data memory combinational read data.

## Operation
- State: DEPTH entries {addr, data}, head/tail pointers, count (0..DEPTH). FIFO order.
- Each cycle the port does exactly one of the following, in priority order:
  - Forced drain: count==DEPTH and (cpu_rd or cpu_wr). stall=1; head is written (mem_wr=1, mem_rd=0); nothing accepted.
  - Load: cpu_rd=1, valid address, not forced. mem_rd=1, mem_addr=cpu_addr, no drain. cpu_rdata is the youngest matching entry's data on a hit, otherwise mem_rdata.
  - Idle drain: cpu_rd=0 and count>0. Head is written and popped.
  - Idle: mem_rd=mem_wr=0, mem_addr=mem_wdata=0.
- Store accept: cpu_wr=1, valid address, stall=0. Push {cpu_addr, cpu_wdata} at tail. Same-address entries are not merged. A push may coincide with an idle-drain pop; count is then unchanged.
- cpu_rd and cpu_wr together: the load is serviced first, then the store is pushed. The load does not see the same-cycle store.
- Invalid address (>= RAM_SIZE): never pushed or passed to memory. cpu_accessable=0 and cpu_rdata=0. Never stalls unless count==DEPTH.

## Timing
- Load latency 0 cycles (combinational, as with direct data memory access). Store posted in 0 cycles. Store visible in memory 1+ cycles after acceptance.
- Memory write commits on the posedge of the drain cycle.
- Stall is a single cycle per forced drain. A retried request is accepted the next cycle, since count then equals DEPTH-1.
- Reset (async, any time, including mid-drain): head=tail=count=0; outputs become stall=0, mem_wr=0, mem_rd=cpu_rd&valid. Entry contents are not reset. Buffered stores are discarded.
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH or underflows.

## Structure
- Shared header MemDefs.v holds RAM_SIZE default and the address-valid compare width. The data memory uses the same header.
- Sub-module sb_match: combinational compare of cpu_addr against all valid entries. Outputs hit and the youngest hit's data, using a priority order from tail-1 back to head.
- Top: pointer/count registers, entry array, and port-priority mux. Roughly 150-250 lines.

## Test plan
- Post 3 stores (addr 1,2,3; data A1,A2,A3) back to back, then idle 3 cycles. Memory must receive writes in order 1,2,3, each on one cycle; count ends at 0; stall stays 0.
- Store 0x10←0x11 then 0x10←0x22, then load 0x10 the next cycle, before any drain. cpu_rdata must be 0x22, and mem_wr must be 0 that cycle.
- Fill 4 entries, then assert cpu_wr 0x20←0x55. stall=1 for one cycle with head drained; accepted the next cycle; final memory[0x20]=0x55.
- Fill 2 entries, then issue continuous loads for 5 cycles. No drain occurs and forwarding stays correct. Drain resumes on the first cycle with cpu_rd=0.
- Store to 300 and load 300 with RAM_SIZE=256. cpu_accessable=0, cpu_rdata=0, no push, no mem strobe.
- Assert reset_n low mid-drain with 3 entries. Count=0 immediately and mem_wr deasserts asynchronously. After release, a load returns memory contents with no forwarding.
